seg_scan_ctrl: RTL and testbench

//   Time-multiplexing scheduler for the shared 4-digit seven-segment display (AN/SEGMENT).

---
 rtl/seg_scan_ctrl_if.sv | 21 ++
 rtl/seg_scan_ctrl.sv | 174 +++++++++++++++++
 tb/tb_seg_scan_ctrl.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/seg_scan_ctrl_if.sv
// Display-side bundle for seg_scan_ctrl: digit data and controls in, board AN/SEGMENT pins and frame pulse out.
// The master modport belongs to the datapath that supplies digit data; the slave modport belongs to the scanner.
interface seg_scan_ctrl_if;
  logic [15:0] digits;
  logic [3:0]  dp;
  logic [3:0]  digit_en;
  logic [3:0]  blink;
  logic [3:0]  AN;
  logic [7:0]  SEGMENT;
  logic        frame_tick;

  modport master (
    output digits, dp, digit_en, blink,
    input  AN, SEGMENT, frame_tick
  );

  modport slave (
    input  digits, dp, digit_en, blink,
    output AN, SEGMENT, frame_tick
  );
endinterface

// File: rtl/seg_scan_ctrl.sv
// 4-digit seven-segment scan scheduler: each digit gets a blanking gap and then a drive slot, in order 0..3.
// Define SEG_BLINK_EN to add frame-counted blinking of digits whose blink bit is set.
module seg_scan_ctrl #(
  parameter int DIGIT_CYCLES = 50000,
  parameter int BLANK_CYCLES = 500,
  parameter int BLINK_FRAMES = 125
) (
  input  logic          clk_50mhz,
  input  logic          rst,
  seg_scan_ctrl_if.slave bus
);

  localparam int MAX_CYCLES = (DIGIT_CYCLES > BLANK_CYCLES) ? DIGIT_CYCLES : BLANK_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0] DRIVE_LAST = CW'(DIGIT_CYCLES - 1);

  typedef enum logic {
    ST_BLANK,
    ST_DRIVE
  } state_e;

  state_e        state_q, state_d;
  logic [1:0]    idx_q, idx_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    nib_q, nib_d;
  logic          dp_sh_q, dp_sh_d;
  logic          en_sh_q, en_sh_d;
  logic [3:0]    an_q, an_d;
  logic [7:0]    seg_q, seg_d;
  logic          tick_q, tick_d;
  logic          latch;
  logic          wrap;
  logic          show;
  logic          hidden;

  // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'h40;
      4'h1: s = 7'h79;
      4'h2: s = 7'h24;
      4'h3: s = 7'h30;
      4'h4: s = 7'h19;
      4'h5: s = 7'h12;
      4'h6: s = 7'h02;
      4'h7: s = 7'h78;
      4'h8: s = 7'h00;
      4'h9: s = 7'h10;
      4'hA: s = 7'h08;
      4'hB: s = 7'h03;
      4'hC: s = 7'h46;
      4'hD: s = 7'h21;
      4'hE: s = 7'h06;
      default: s = 7'h0E;
    endcase
    return s;
  endfunction

`ifdef SEG_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FRAME_LAST = FW'(BLINK_FRAMES - 1);

  logic          blink_sh_q, blink_sh_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic          phase_q, phase_d;

  // Phase flips only at a frame wrap, so it is already settled whenever a slot latches.
  always_comb begin
    blink_sh_d  = latch ? bus.blink[idx_q] : blink_sh_q;
    frame_cnt_d = frame_cnt_q;
    phase_d     = phase_q;
    if (wrap) begin
      if (frame_cnt_q == FRAME_LAST) begin
        frame_cnt_d = '0;
        phase_d     = ~phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      blink_sh_q  <= 1'b0;
      frame_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      blink_sh_q  <= blink_sh_d;
      frame_cnt_q <= frame_cnt_d;
      phase_q     <= phase_d;
    end
  end

  assign hidden = blink_sh_d & phase_q;
`else
  logic unused_blink;
  assign unused_blink = ^bus.blink;
  assign hidden       = 1'b0;
`endif

  // Next-state logic; outputs are derived from the next state so they line up with it exactly.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    latch   = 1'b0;
    wrap    = 1'b0;
    case (state_q)
      ST_BLANK: begin
        if (cnt_q == BLANK_LAST) begin
          cnt_d   = '0;
          state_d = ST_DRIVE;
          latch   = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DRIVE: begin
        if (cnt_q == DRIVE_LAST) begin
          cnt_d   = '0;
          state_d = ST_BLANK;
          idx_d   = idx_q + 2'd1;
          wrap    = (idx_q == 2'd3);
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_BLANK;
        cnt_d   = '0;
      end
    endcase

    nib_d   = latch ? bus.digits[{idx_q, 2'b00} +: 4] : nib_q;
    dp_sh_d = latch ? bus.dp[idx_q]                  : dp_sh_q;
    en_sh_d = latch ? bus.digit_en[idx_q]            : en_sh_q;

    show   = (state_d == ST_DRIVE) && en_sh_d && !hidden;
    an_d   = show ? ~(4'b0001 << idx_q) : 4'hF;
    seg_d  = show ? {~dp_sh_d, hex7(nib_d)} : 8'hFF;
    tick_d = wrap;
  end

  always_ff @(posedge clk_50mhz) begin
    if (rst) begin
      state_q <= ST_BLANK;
      idx_q   <= 2'd0;
      cnt_q   <= '0;
      nib_q   <= 4'h0;
      dp_sh_q <= 1'b0;
      en_sh_q <= 1'b0;
      an_q    <= 4'hF;
      seg_q   <= 8'hFF;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      nib_q   <= nib_d;
      dp_sh_q <= dp_sh_d;
      en_sh_q <= en_sh_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      tick_q  <= tick_d;
    end
  end

  assign bus.AN         = an_q;
  assign bus.SEGMENT    = seg_q;
  assign bus.frame_tick = tick_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: a timeline model (cycle count since reset -> slot/phase) checked every cycle,
// plus directed literal checks on reset, digit order, enables, mid-slot data changes and blinking.
module tb_seg_scan_ctrl;

  localparam int DIGIT = 4;
  localparam int BLANK = 2;
  localparam int FRAMES = 2;
  localparam int SLOT = DIGIT + BLANK;
  localparam int PERIOD = 4 * SLOT;

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  seg_scan_ctrl_if bus ();

  seg_scan_ctrl #(
    .DIGIT_CYCLES(DIGIT),
    .BLANK_CYCLES(BLANK),
    .BLINK_FRAMES(FRAMES)
  ) dut (
    .clk_50mhz(clk),
    .rst      (rst),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Segment patterns straight from the display's character table.
  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Model: m_t counts cycles since reset; each slot's data is captured when its blanking gap ends.
  int       m_t = 0;
  bit       m_valid = 1'b0;
  logic [3:0] lat_nib [4];
  logic       lat_dp  [4];
  logic       lat_en  [4];
  logic       lat_bl  [4];

  always @(posedge clk) begin
    if (rst) begin
      m_t     <= 0;
      m_valid <= 1'b1;
    end else if (m_valid) begin
      if (((m_t % PERIOD) % SLOT) == BLANK - 1) begin
        int s;
        s = (m_t % PERIOD) / SLOT;
        lat_nib[s] <= bus.digits[s*4 +: 4];
        lat_dp[s]  <= bus.dp[s];
        lat_en[s]  <= bus.digit_en[s];
        lat_bl[s]  <= bus.blink[s];
      end
      m_t <= m_t + 1;
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      int pos, s;
      bit lit, hide;
      logic [3:0] e_an;
      logic [7:0] e_seg;
      logic       e_tick;
      pos  = m_t % PERIOD;
      s    = pos / SLOT;
      hide = 1'b0;
`ifdef SEG_BLINK_EN
      hide = lat_bl[s] && (((m_t / PERIOD) / FRAMES) % 2 == 1);
`endif
      lit    = ((pos % SLOT) >= BLANK) && lat_en[s] && !hide;
      e_an   = lit ? ~(4'b0001 << s) : 4'hF;
      e_seg  = lit ? {~lat_dp[s], hex_tab[lat_nib[s]]} : 8'hFF;
      e_tick = (pos == 0) && (m_t >= PERIOD);
      checks++;
      if (bus.AN !== e_an || bus.SEGMENT !== e_seg || bus.frame_tick !== e_tick) begin
        errors++;
        $display("[TB] FAIL model t=%0d: got AN=%b SEG=%h tick=%b, expected AN=%b SEG=%h tick=%b",
                 m_t, bus.AN, bus.SEGMENT, bus.frame_tick, e_an, e_seg, e_tick);
      end
    end
  end

  task automatic applyStimulus(input logic [15:0] d, input logic [3:0] p,
                               input logic [3:0] en, input logic [3:0] bl);
    bus.digits   = d;
    bus.dp       = p;
    bus.digit_en = en;
    bus.blink    = bl;
  endtask

  task automatic checkOutput(input string name, input logic [3:0] e_an,
                             input logic [7:0] e_seg, input logic e_tick);
    checks++;
    if (bus.AN !== e_an || bus.SEGMENT !== e_seg || bus.frame_tick !== e_tick) begin
      errors++;
      $display("[TB] FAIL %s: got AN=%b SEG=%h tick=%b, expected AN=%b SEG=%h tick=%b",
               name, bus.AN, bus.SEGMENT, bus.frame_tick, e_an, e_seg, e_tick);
    end
  endtask

  task automatic waitT(input int target);
    for (int i = 0; i < 400 && m_t != target; i++) @(negedge clk);
    if (m_t != target) begin
      checks++;
      errors++;
      $display("[TB] FAIL timeout waiting for t=%0d: got t=%0d", target, m_t);
    end
  endtask

  task automatic resetDut();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("reset_held_1", 4'hF, 8'hFF, 1'b0);
    @(negedge clk);
    checkOutput("reset_held_2", 4'hF, 8'hFF, 1'b0);
    rst = 1'b0;
  endtask

  logic [5:0] lit_frames = 6'b110011;
  int         bad_an;

  initial begin
    rst = 1'b0;
    applyStimulus(16'h8A30, 4'b0001, 4'hF, 4'h0);
    resetDut();

    $display("[TB] digit order and segment decode");
    waitT(1);  checkOutput("blank_before_d0", 4'hF, 8'hFF, 1'b0);
    waitT(2);  checkOutput("d0_first",        4'b1110, 8'h40, 1'b0);
    waitT(5);  checkOutput("d0_last",         4'b1110, 8'h40, 1'b0);
    waitT(6);  checkOutput("gap_after_d0",    4'hF, 8'hFF, 1'b0);
    waitT(8);  checkOutput("d1",              4'b1101, 8'hB0, 1'b0);
    waitT(14); checkOutput("d2",              4'b1011, 8'h88, 1'b0);
    waitT(20); checkOutput("d3",              4'b0111, 8'h80, 1'b0);
    waitT(24); checkOutput("tick_frame1",     4'hF, 8'hFF, 1'b1);
    waitT(25); checkOutput("tick_one_cycle",  4'hF, 8'hFF, 1'b0);
    waitT(48); checkOutput("tick_frame2",     4'hF, 8'hFF, 1'b1);

    $display("[TB] reset during digit 1 drive");
    waitT(57);
    rst = 1'b1;
    @(negedge clk);
    checkOutput("mid_slot_reset", 4'hF, 8'hFF, 1'b0);
    rst = 1'b0;
    waitT(1); checkOutput("post_reset_dark", 4'hF, 8'hFF, 1'b0);
    waitT(2); checkOutput("post_reset_d0",   4'b1110, 8'h40, 1'b0);
    waitT(5); checkOutput("post_reset_d0_end", 4'b1110, 8'h40, 1'b0);
    waitT(6); checkOutput("post_reset_gap",  4'hF, 8'hFF, 1'b0);

    $display("[TB] digit enables");
    applyStimulus(16'h8A30, 4'b0001, 4'b0101, 4'h0);
    bad_an = 0;
    for (int i = 0; i < 2 * PERIOD; i++) begin
      @(negedge clk);
      if (m_t >= 8 && (bus.AN == 4'b1101 || bus.AN == 4'b0111)) bad_an++;
    end
    checks++;
    if (bad_an != 0) begin
      errors++;
      $display("[TB] FAIL disabled_digits: got %0d lit cycles, expected 0", bad_an);
    end
    waitT(62); checkOutput("en_d2_lit", 4'b1011, 8'h88, 1'b0);
    waitT(72); checkOutput("en_tick",   4'hF, 8'hFF, 1'b1);

    $display("[TB] mid-slot data change");
    applyStimulus(16'h0000, 4'b0000, 4'hF, 4'h0);
    waitT(80); checkOutput("chg_d1_before", 4'b1101, 8'hC0, 1'b0);
    waitT(81);
    applyStimulus(16'hFFFF, 4'b0000, 4'hF, 4'h0);
    waitT(82); checkOutput("chg_d1_hold",   4'b1101, 8'hC0, 1'b0);
    waitT(83); checkOutput("chg_d1_end",    4'b1101, 8'hC0, 1'b0);
    waitT(86); checkOutput("chg_d2_new",    4'b1011, 8'h8E, 1'b0);

    $display("[TB] blinking digit 0");
    applyStimulus(16'h0000, 4'b0000, 4'hF, 4'b0001);
    resetDut();
    for (int f = 0; f < 6; f++) begin
      bit lit;
`ifdef SEG_BLINK_EN
      lit = lit_frames[f];
`else
      lit = 1'b1;
`endif
      waitT(f * PERIOD + BLANK + 1);
      checkOutput($sformatf("blink_frame%0d", f), lit ? 4'b1110 : 4'hF, lit ? 8'hC0 : 8'hFF, 1'b0);
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
